// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction width and NOP word.
package fetch_ctrl_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_HALT  = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_ifid_reg.sv
// IF/ID pipeline register: flush clears to NOP, hold freezes, load captures a new instruction.
module ifid_reg
  import fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              hold,
  input  logic              flush,
  input  logic              load,
  input  logic [INST_W-1:0] inst_in,
  input  logic [31:0]       pc4_in,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       pc4,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      inst  <= NOP;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      inst  <= NOP;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (!hold && load) begin
      inst  <= inst_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, run/halt/fault FSM, IF/ID loading and fetch counter.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IM_DEPTH = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       im_pc,
  input  logic [INST_W-1:0] im_data,
  output logic [INST_W-1:0] ifid_inst,
  output logic [31:0]       ifid_pc4,
  output logic              ifid_valid,
  output logic              fault,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  fetch_cnt
);

  fetch_state_e fsm;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         misaligned;
  logic         out_of_range;
  logic         ifid_hold;
  logic         ifid_flush;
  logic         ifid_load;

  assign pc_plus4     = pc + 32'd4;
  assign misaligned   = |redirect_pc[1:0];
  assign out_of_range = {2'b00, pc[31:2]} >= 32'(IM_DEPTH);
  assign im_pc        = pc;
  assign state        = fsm;

  // IF/ID controls follow the same priority as the RUN branch of the FSM below.
  always_comb begin
    ifid_flush = 1'b1;
    ifid_hold  = 1'b0;
    ifid_load  = 1'b0;
    if (fsm == FS_RUN && !halt_req && run && !redirect) begin
      if (stall) begin
        ifid_flush = 1'b0;
        ifid_hold  = 1'b1;
      end else if (!out_of_range) begin
        ifid_flush = 1'b0;
        ifid_load  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm       <= FS_IDLE;
      pc        <= RESET_PC;
      fault     <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      case (fsm)
        FS_IDLE: if (run) fsm <= FS_RUN;
        FS_RUN: begin
          if (halt_req) begin
            fsm <= FS_HALT;
          end else if (!run) begin
            fsm <= FS_IDLE;
          end else if (redirect) begin
            if (misaligned) begin
              fsm   <= FS_FAULT;
              fault <= 1'b1;
            end else begin
              pc <= redirect_pc;
            end
          end else if (stall) begin
            pc <= pc;
          end else if (out_of_range) begin
            fsm <= FS_HALT;
          end else begin
            pc <= pc_plus4;
            if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + CNT_W'(1);
          end
        end
        FS_HALT: if (!run && !halt_req) fsm <= FS_IDLE;
        default: fsm <= FS_FAULT;
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk     (clk),
    .rstn    (rstn),
    .hold    (ifid_hold),
    .flush   (ifid_flush),
    .load    (ifid_load),
    .inst_in (im_data),
    .pc4_in  (pc_plus4),
    .inst    (ifid_inst),
    .pc4     (ifid_pc4),
    .valid   (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver queues hand-computed post-edge snapshots, monitor checks them.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rstn, run, halt_req, stall, redirect;
  logic [31:0] redirect_pc, im_pc, im_data, ifid_inst, ifid_pc4;
  logic        ifid_valid, fault;
  logic [1:0]  state;
  logic [3:0]  fetch_cnt;

  logic [31:0] mem [64];

  typedef struct {
    int          id;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  st;
    logic        flt;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  fetch_ctrl #(.RESET_PC(32'h0), .IM_DEPTH(64), .CNT_W(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .run         (run),
    .halt_req    (halt_req),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_pc       (im_pc),
    .im_data     (im_data),
    .ifid_inst   (ifid_inst),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .fault       (fault),
    .state       (state),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    im_data = '0;
    if (im_pc[31:8] == 24'h0) im_data = mem[im_pc[7:2]];
  end

  task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Inputs for the next edge, plus the outputs expected right after it.
  task automatic step(input logic r_n, input logic r, input logic h, input logic s,
                      input logic rd, input logic [31:0] rpc,
                      input logic [31:0] e_inst, input logic [31:0] e_pc4, input logic e_valid,
                      input logic [31:0] e_pc, input logic [1:0] e_st, input logic e_flt,
                      input logic [3:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rstn = r_n; run = r; halt_req = h; stall = s; redirect = rd; redirect_pc = rpc;
    e.id = step_id; e.inst = e_inst; e.pc4 = e_pc4; e.valid = e_valid;
    e.pc = e_pc; e.st = e_st; e.flt = e_flt; e.cnt = e_cnt;
    sb.push_back(e);
    step_id++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.id, "ifid_inst",  ifid_inst,         e.inst);
        chk(e.id, "ifid_pc4",   ifid_pc4,          e.pc4);
        chk(e.id, "ifid_valid", 32'(ifid_valid),   32'(e.valid));
        chk(e.id, "im_pc",      im_pc,             e.pc);
        chk(e.id, "state",      32'(state),        32'(e.st));
        chk(e.id, "fault",      32'(fault),        32'(e.flt));
        chk(e.id, "fetch_cnt",  32'(fetch_cnt),    32'(e.cnt));
      end
    end
  end

  localparam logic [1:0] I = 2'd0, R = 2'd1, H = 2'd2, F = 2'd3;

  initial begin : driver
    int wait_cycles;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h3404_0050;
    mem[1] = 32'h8c88_0000;
    mem[2] = 32'h2084_0004;
    rstn = 1'b0; run = 1'b0; halt_req = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    //    rstn run halt stall redir rpc       inst          pc4       v  pc         st flt cnt
    step(0, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h0,   I, 0, 0);
    step(0, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h0,   I, 0, 0);
    step(1, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h0,   R, 0, 0);
    step(1, 1, 0, 0, 0, 32'h0,   32'h3404_0050, 32'h4,   1, 32'h4,   R, 0, 1);
    step(1, 1, 0, 0, 0, 32'h0,   32'h8c88_0000, 32'h8,   1, 32'h8,   R, 0, 2);
    step(1, 1, 0, 0, 0, 32'h0,   32'h2084_0004, 32'hC,   1, 32'hC,   R, 0, 3);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_0003, 32'h10,  1, 32'h10,  R, 0, 4);
    // stall at PC=0x10, then the held fetch completes
    step(1, 1, 0, 1, 0, 32'h0,   32'hA000_0003, 32'h10,  1, 32'h10,  R, 0, 4);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_0004, 32'h14,  1, 32'h14,  R, 0, 5);
    // redirect beats stall
    step(1, 1, 0, 1, 1, 32'h40,  32'h0,        32'h0,    0, 32'h40,  R, 0, 5);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_0010, 32'h44,  1, 32'h44,  R, 0, 6);
    // run off the end of instruction memory
    step(1, 1, 0, 0, 1, 32'hF8,  32'h0,        32'h0,    0, 32'hF8,  R, 0, 6);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_003E, 32'hFC,  1, 32'hFC,  R, 0, 7);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_003F, 32'h100, 1, 32'h100, R, 0, 8);
    step(1, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h100, H, 0, 8);
    step(1, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h100, H, 0, 8);
    step(1, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h100, I, 0, 8);
    // out-of-range redirect target accepted, HALT on the following edge
    step(1, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h100, R, 0, 8);
    step(1, 1, 0, 0, 1, 32'h200, 32'h0,        32'h0,    0, 32'h200, R, 0, 8);
    step(1, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h200, H, 0, 8);
    step(1, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h200, I, 0, 8);
    // halt_req, then resume at held PC
    step(1, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h200, R, 0, 8);
    step(1, 1, 0, 0, 1, 32'h8,   32'h0,        32'h0,    0, 32'h8,   R, 0, 8);
    step(1, 1, 0, 0, 0, 32'h0,   32'h2084_0004, 32'hC,   1, 32'hC,   R, 0, 9);
    step(1, 1, 1, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'hC,   H, 0, 9);
    step(1, 0, 1, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'hC,   H, 0, 9);
    step(1, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'hC,   I, 0, 9);
    step(1, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'hC,   R, 0, 9);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_0003, 32'h10,  1, 32'h10,  R, 0, 10);
    // run dropped while in RUN
    step(1, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h10,  I, 0, 10);
    step(1, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h10,  R, 0, 10);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_0004, 32'h14,  1, 32'h14,  R, 0, 11);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_0005, 32'h18,  1, 32'h18,  R, 0, 12);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_0006, 32'h1C,  1, 32'h1C,  R, 0, 13);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_0007, 32'h20,  1, 32'h20,  R, 0, 14);
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_0008, 32'h24,  1, 32'h24,  R, 0, 15);
    // counter saturates at all-ones
    step(1, 1, 0, 0, 0, 32'h0,   32'hA000_0009, 32'h28,  1, 32'h28,  R, 0, 15);
    // misaligned redirect -> terminal FAULT
    step(1, 1, 0, 0, 1, 32'h22,  32'h0,        32'h0,    0, 32'h28,  F, 1, 15);
    step(1, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h28,  F, 1, 15);
    step(1, 1, 1, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h28,  F, 1, 15);
    step(1, 1, 0, 0, 1, 32'h40,  32'h0,        32'h0,    0, 32'h28,  F, 1, 15);
    step(0, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h0,   I, 0, 0);
    // reset in RUN with stall and redirect asserted
    step(1, 1, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h0,   R, 0, 0);
    step(1, 1, 0, 0, 0, 32'h0,   32'h3404_0050, 32'h4,   1, 32'h4,   R, 0, 1);
    step(0, 1, 0, 1, 1, 32'h40,  32'h0,        32'h0,    0, 32'h0,   I, 0, 0);
    step(1, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,    0, 32'h0,   I, 0, 0);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
